fetch_pc: RTL
=============

# fetch_pc

Instruction-fetch program-counter stage of the CPU pipeline. It generates sequential fetch addresses and drives the instruction-memory request handshake. It presents fetched instructions to decode through a one-entry skid buffer. It consumes the execute-stage branch decision (taken flag plus target) to redirect fetch and flush younger instructions.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; asynchronous assertion, active-low
- i_stall  in  1  decode cannot accept; holds o_vld/o_instr/o_pc
- i_exec_vld  in  1  execute stage holds a valid instruction
- i_br_en  in  1  branch/jump taken, from execute-stage branch unit
- i_br_tgt  in  32  redirect target address
- o_imem_req  out  1  memory request valid
- o_imem_addr  out  32  request address, word-aligned
- i_imem_ack  in  1  request accepted, data valid this cycle
- i_imem_dat  in  32  instruction word
- o_vld  out  1  o_instr/o_pc valid to decode
- o_instr  out  32  fetched instruction
- o_pc  out  32  address of o_instr
- o_flush  out  1  kill IF/ID contents (combinational)
- o_misalign  out  1  one-cycle pulse: misaligned redirect target
- o_misalign_addr  out  32  offending target, valid with o_misalign

## Operation
- Redirect event R = i_exec_vld & i_br_en & (i_br_tgt[1:0]==0); misaligned event M = i_exec_vld & i_br_en & (i_br_tgt[1:0]!=0).
- o_flush = R, combinational.
- State machine:
  - BOOT: entered from reset, lasts 1 cycle, no request; next state IDLE with fetch address = RESET_VECTOR.
  - IDLE: request slot free. Moves to WAIT when the skid is empty and no R.
  - WAIT: o_imem_req=1 and o_imem_addr is stable until i_imem_ack.
  - DRAIN: an old request is still outstanding after a redirect; its data is discarded on ack.
- WAIT with ack and no R:
  - Data goes to the output register if !o_vld | !i_stall; otherwise it goes to the skid.
  - Address becomes addr+4 (wraps modulo 2^32).
  - Stays in WAIT if the skid will be empty after this edge; otherwise goes to IDLE.
- Output drain: when o_vld & !i_stall, the skid contents (if any) move to the output; else o_vld drops.
- R in any state:
  - Output and skid are invalidated at the edge.
  - Fetch address becomes i_br_tgt.
  - WAIT without ack goes to DRAIN; WAIT with ack discards the data and goes to WAIT at the target.
  - IDLE goes to WAIT at the target.
- DRAIN:
  - A further R replaces the stored target; the latest wins.
  - On ack, data is discarded and the state goes to WAIT at the stored target.
- M: no redirect and no flush. o_misalign=1 with o_misalign_addr=i_br_tgt in the next cycle; fetch continues unaffected.
- Priority: reset > R > ack > stall.

## Timing
- Reset values:
  - o_imem_req=0, o_imem_addr=RESET_VECTOR
  - o_vld=0, o_instr=0, o_pc=0
  - o_misalign=0, o_misalign_addr=0
  - state BOOT, skid empty
- Async reset mid-request abandons the outstanding request with no ack bookkeeping.
- Fetch latency: ack in cycle N gives o_vld=1 with o_instr/o_pc in N+1.
- Throughput: one instruction per cycle with a zero-wait memory and no stall.
- Redirect: R in cycle N gives the target request in N+1 if no request was outstanding, or in the cycle after the draining ack.
- A request once raised is never withdrawn or altered before ack, except by reset.

## Structure
- Shared CPU constants package: RESET_VECTOR default, fetch state encodings (BOOT/IDLE/WAIT/DRAIN), instruction width.
- One sub-module: fetch_skid, a one-entry {pc, instr} buffer with load/unload/clear.

## Test plan
- Reset release, RESET_VECTOR=0, always-ack memory -> addresses 0,4,8,12 on consecutive cycles; o_pc follows one cycle after each ack.
- i_stall high 3 cycles while o_vld=1 and an ack arrives -> o_instr/o_pc held and the skid fills; no new request; after release, PCs are emitted in order with no loss.
- R with i_br_tgt=0x100 while a request for 0x20 is unacked -> DRAIN; 0x20 data dropped; next request 0x100; o_flush=1 only in the R cycle.
- R and ack in the same cycle, target 0x40 -> ack data discarded, next o_imem_addr=0x40, o_vld=0 next cycle.
- i_br_en with i_br_tgt=0x102 -> no flush; o_misalign pulse with addr 0x102; sequential fetch continues.
- Reset asserted while in WAIT -> outputs immediately at reset values; refetch starts from RESET_VECTOR after BOOT.

Source files
------------

// File: rtl/fetch_pc_pkg.sv
// fetch_pc_pkg: shared CPU constants for the instruction-fetch stage.
// Fetch FSM encodings, widths and the IF/ID entry bundle.
package fetch_pc_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_ent_t;

    function automatic logic is_aligned(input logic [XLEN-1:0] a);
        return a[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry {pc, instr} holding buffer between IF and ID.
// Clear wins over load; load and unload are never asserted together.
module fetch_skid
    import fetch_pc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       unload,
    input  logic       clear,
    input  fetch_ent_t din,
    output logic       vld,
    output fetch_ent_t dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            dout <= '0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (load) begin
            vld  <= 1'b1;
            dout <= din;
        end else if (unload) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// fetch_pc: IF program-counter stage; sequential fetch, imem handshake,
// branch redirect with drain of an in-flight request, skid to decode.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_exec_vld,
    input  logic               i_br_en,
    input  logic [XLEN-1:0]    i_br_tgt,
    output logic               o_imem_req,
    output logic [XLEN-1:0]    o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_dat,
    output logic               o_vld,
    output logic [INSTR_W-1:0] o_instr,
    output logic [XLEN-1:0]    o_pc,
    output logic               o_flush,
    output logic               o_misalign,
    output logic [XLEN-1:0]    o_misalign_addr
);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] addr_nxt;
    logic [XLEN-1:0] drain_tgt;
    logic [XLEN-1:0] drain_tgt_nxt;

    logic       br;
    logic       redir;
    logic       mis_ev;
    logic       wait_ack;
    logic       fetch_ok;
    logic       load_out;
    logic       out_adv;
    logic       skid_load;
    logic       skid_unload;
    logic       skid_vld;
    fetch_ent_t skid_q;
    fetch_ent_t new_ent;
    fetch_ent_t out_q;
    logic       out_vld;

    assign br     = i_exec_vld & i_br_en;
    assign redir  = br & is_aligned(i_br_tgt);
    assign mis_ev = br & ~is_aligned(i_br_tgt);

    assign wait_ack    = (state == ST_WAIT) & i_imem_ack;
    assign fetch_ok    = wait_ack & ~redir;
    assign load_out    = fetch_ok & (~out_vld | ~i_stall);
    assign out_adv     = out_vld & ~i_stall;
    assign skid_load   = fetch_ok & out_vld & i_stall;
    assign skid_unload = out_adv & skid_vld & ~redir & ~load_out;

    assign new_ent.pc    = addr;
    assign new_ent.instr = i_imem_dat;

    // DRAIN keeps the old address on the bus; the target waits aside
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        drain_tgt_nxt = drain_tgt;
        case (state)
            ST_BOOT: begin
                if (redir) begin
                    addr_nxt  = i_br_tgt;
                    state_nxt = ST_WAIT;
                end else begin
                    addr_nxt  = RESET_VECTOR;
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (redir) begin
                    addr_nxt  = i_br_tgt;
                    state_nxt = ST_WAIT;
                end else if (!skid_vld) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redir) begin
                    if (i_imem_ack) begin
                        addr_nxt = i_br_tgt;
                    end else begin
                        drain_tgt_nxt = i_br_tgt;
                        state_nxt     = ST_DRAIN;
                    end
                end else if (i_imem_ack) begin
                    addr_nxt  = addr + 32'd4;
                    state_nxt = skid_load ? ST_IDLE : ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (i_imem_ack) begin
                    addr_nxt  = redir ? i_br_tgt : drain_tgt;
                    state_nxt = ST_WAIT;
                end else if (redir) begin
                    drain_tgt_nxt = i_br_tgt;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_BOOT;
            addr      <= RESET_VECTOR;
            drain_tgt <= RESET_VECTOR;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            drain_tgt <= drain_tgt_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (redir) begin
            out_vld <= 1'b0;
        end else if (load_out) begin
            out_vld <= 1'b1;
            out_q   <= new_ent;
        end else if (out_adv) begin
            out_vld <= skid_vld;
            if (skid_vld) begin
                out_q <= skid_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_misalign      <= 1'b0;
            o_misalign_addr <= '0;
        end else begin
            o_misalign <= mis_ev;
            if (mis_ev) begin
                o_misalign_addr <= i_br_tgt;
            end
        end
    end

    fetch_skid u_skid (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (redir),
        .din    (new_ent),
        .vld    (skid_vld),
        .dout   (skid_q)
    );

    assign o_imem_req  = (state == ST_WAIT) | (state == ST_DRAIN);
    assign o_imem_addr = addr;
    assign o_vld       = out_vld;
    assign o_pc        = out_q.pc;
    assign o_instr     = out_q.instr;
    assign o_flush     = redir;

endmodule
